// File: rtl/data_mem_ctrl.sv
// Data-memory controller: single-port word array, FIFO store buffer drained on idle
// load cycles, youngest-entry store-to-load forwarding, and out-of-range fault detection.
module data_mem_ctrl #(
    parameter int unsigned          ADDR_W     = 16,
    parameter int unsigned          DATA_W     = 32,
    parameter int unsigned          MEM_DEPTH  = 256,
    parameter int unsigned          SB_DEPTH   = 4,
    parameter logic [DATA_W-1:0]    FAULT_WORD = 32'hFFFFFFFF,
    parameter int unsigned          TAG_W      = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ld_req,
    input  logic [ADDR_W-1:0]             ld_addr,
    input  logic [TAG_W-1:0]              ld_tag,
    output logic                          ld_valid,
    output logic [DATA_W-1:0]             ld_data,
    output logic [TAG_W-1:0]              ld_tag_out,
    output logic                          ld_fault,
    input  logic                          st_req,
    input  logic [ADDR_W-1:0]             st_addr,
    input  logic [DATA_W-1:0]             st_data,
    output logic                          st_ready,
    output logic                          st_fault,
    output logic [$clog2(SB_DEPTH):0]     sb_count
);

    localparam int unsigned MA_W  = $clog2(MEM_DEPTH);
    localparam int unsigned PTR_W = $clog2(SB_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [ADDR_W:0]  MEM_LIMIT = (ADDR_W+1)'(MEM_DEPTH);
    localparam logic [CNT_W-1:0] SB_FULL   = CNT_W'(SB_DEPTH);

    logic [DATA_W-1:0] r_mem     [MEM_DEPTH];
    logic [ADDR_W-1:0] r_sb_addr [SB_DEPTH];
    logic [DATA_W-1:0] r_sb_data [SB_DEPTH];

    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    logic              r_ld_valid;
    logic [DATA_W-1:0] r_ld_data;
    logic [TAG_W-1:0]  r_ld_tag;
    logic              r_ld_fault;
    logic              r_st_fault;

    logic              w_ld_oor;
    logic              w_st_oor;
    logic              w_st_ready;
    logic              w_st_acc;
    logic              w_push;
    logic              w_pop;
    logic              w_fwd_hit;
    logic [DATA_W-1:0] w_fwd_data;
    logic [PTR_W-1:0]  w_idx;

    assign w_ld_oor   = {1'b0, ld_addr} >= MEM_LIMIT;
    assign w_st_oor   = {1'b0, st_addr} >= MEM_LIMIT;
    assign w_st_ready = r_count < SB_FULL;
    assign w_st_acc   = st_req && w_st_ready;
    assign w_push     = w_st_acc && !w_st_oor;
    assign w_pop      = (r_count != '0) && !ld_req;

    // Walk entries oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        w_idx      = '0;
        for (int unsigned i = 0; i < SB_DEPTH; i++) begin
            w_idx = r_head + PTR_W'(i);
            if ((CNT_W'(i) < r_count) && (r_sb_addr[w_idx] == ld_addr)) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_sb_data[w_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_pop)
            r_mem[r_sb_addr[r_head][MA_W-1:0]] <= r_sb_data[r_head];
        if (w_push) begin
            r_sb_addr[r_tail] <= st_addr;
            r_sb_data[r_tail] <= st_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_st_fault <= 1'b0;
        end else begin
            r_st_fault <= w_st_acc && w_st_oor;
            if (w_push)
                r_tail <= r_tail + 1'b1;
            if (w_pop)
                r_head <= r_head + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (!w_push && w_pop)
                r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ld_valid <= 1'b0;
            r_ld_data  <= '0;
            r_ld_tag   <= '0;
            r_ld_fault <= 1'b0;
        end else begin
            r_ld_valid <= ld_req;
            r_ld_fault <= ld_req && w_ld_oor;
            if (ld_req) begin
                r_ld_tag <= ld_tag;
                if (w_ld_oor)
                    r_ld_data <= FAULT_WORD;
                else if (w_fwd_hit)
                    r_ld_data <= w_fwd_data;
                else
                    r_ld_data <= r_mem[ld_addr[MA_W-1:0]];
            end
        end
    end

    assign ld_valid   = r_ld_valid;
    assign ld_data    = r_ld_data;
    assign ld_tag_out = r_ld_tag;
    assign ld_fault   = r_ld_fault;
    assign st_ready   = w_st_ready;
    assign st_fault   = r_st_fault;
    assign sb_count   = r_count;

endmodule
